fir_coef_loader: RTL and testbench

//  Initiator for the FIR configuration port and gatekeeper of its sample input.
//  - Holds a shadow bank of WINLEN coefficients that a host writes.
//  - On command, streams the whole bank into parallel_fir over cfg_valid/cfg_busy/cfg_addr/cfg_data.
//  - Blocks the sample stream into fir_din_* until a complete load has finished.
//  - Sits directly upstream of parallel_fir, between host control and the sample source.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_coef_bank.sv | 43 ++++
 rtl/fir_coef_loader.sv | 144 ++++++++++++++
 tb/tb_fir_coef_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Types and handshake helpers shared between the FIR and its coefficient loader.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        LOAD = 2'd2
    } ldr_state_e;

    function automatic logic beat_fire(input logic valid, input logic busy);
        return valid & ~busy;
    endfunction

    function automatic logic beat_stall(input logic valid, input logic busy);
        return valid & busy;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow coefficient register file: one write port, one combinational read port.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 6,
    parameter int WINLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_r [WINLEN];

    // Storage array, cleared on reset, one word written per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WINLEN; i++) begin
                mem_r[i] <= {DWIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < WINLEN; i++) begin
                if (we && (waddr == AWIDTH'(i))) begin
                    mem_r[i] <= wdata;
                end
            end
        end
    end

    // Read mux; out-of-range addresses read as zero
    always_comb begin
        rdata = {DWIDTH{1'b0}};
        for (int i = 0; i < WINLEN; i++) begin
            rdata = rdata | ((raddr == AWIDTH'(i)) ? mem_r[i] : {DWIDTH{1'b0}});
        end
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Streams the shadow coefficient bank into the FIR and gates the sample stream
// until a complete load has finished.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 6,
    parameter int WINLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_we,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_data,
    output logic              host_err,
    input  logic              load_start,
    output logic              load_busy,
    output logic              load_done,
    output logic              coef_ok,
    output logic              cfg_valid,
    input  logic              cfg_busy,
    output logic [AWIDTH-1:0] cfg_addr,
    output logic [DWIDTH-1:0] cfg_data,
    input  logic              src_valid,
    output logic              src_busy,
    input  logic [DWIDTH-1:0] src_data,
    output logic              fir_din_valid,
    input  logic              fir_din_busy,
    output logic [DWIDTH-1:0] fir_din_data
);

    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(WINLEN - 1);

    ldr_state_e        state_r, next_state_s;
    logic              pend_r, pass_s, pass_q_s, din_stall_s;
    logic              cfg_valid_r, load_busy_r, load_done_r, coef_ok_r, host_err_r;
    logic [AWIDTH-1:0] cfg_addr_r, rd_addr_s;
    logic [DWIDTH-1:0] cfg_data_r, rd_data_s;
    logic              cfg_fire_s, last_beat_s, enter_load_s, wr_ok_s;

    fir_coef_bank #(
        .DWIDTH(DWIDTH),
        .AWIDTH(AWIDTH),
        .WINLEN(WINLEN)
    ) u_bank (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (wr_ok_s),
        .waddr(host_addr),
        .wdata(host_data),
        .raddr(rd_addr_s),
        .rdata(rd_data_s)
    );

    // Sample gate: a beat already offered to the FIR keeps the gate open until it transfers
    always_comb begin
        pass_s        = coef_ok_r & (state_r == IDLE);
        pass_q_s      = pass_s | pend_r;
        fir_din_valid = src_valid & pass_q_s;
        src_busy      = fir_din_busy | ~pass_q_s;
        fir_din_data  = src_data;
        din_stall_s   = beat_stall(fir_din_valid, fir_din_busy);
    end

    // Next-state logic, beat bookkeeping and bank read address
    always_comb begin
        next_state_s = state_r;
        cfg_fire_s   = beat_fire(cfg_valid_r, cfg_busy);
        last_beat_s  = cfg_fire_s & (state_r == LOAD) & (cfg_addr_r == LAST_IDX);
        wr_ok_s      = host_we & (state_r == IDLE) & (int'(host_addr) < WINLEN);
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    next_state_s = din_stall_s ? GATE : LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GATE: begin
                if (!din_stall_s) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = GATE;
                end
            end
            LOAD: begin
                if (last_beat_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = LOAD;
                end
            end
            default: next_state_s = IDLE;
        endcase
        enter_load_s = (next_state_s == LOAD) & (state_r != LOAD);
        rd_addr_s    = enter_load_s ? {AWIDTH{1'b0}} : (cfg_addr_r + AWIDTH'(1));
    end

    // State, status flags and the pending-din-beat tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            load_busy_r <= 1'b0;
            load_done_r <= 1'b0;
            coef_ok_r   <= 1'b0;
            host_err_r  <= 1'b0;
            pend_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            load_busy_r <= (next_state_s != IDLE);
            load_done_r <= last_beat_s;
            coef_ok_r   <= coef_ok_r | last_beat_s;
            host_err_r  <= host_we & ~wr_ok_s;
            pend_r      <= din_stall_s;
        end
    end

    // Coefficient beat registers; the index stops at the last tap and never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_valid_r <= 1'b0;
            cfg_addr_r  <= {AWIDTH{1'b0}};
            cfg_data_r  <= {DWIDTH{1'b0}};
        end else if (enter_load_s) begin
            cfg_valid_r <= 1'b1;
            cfg_addr_r  <= {AWIDTH{1'b0}};
            cfg_data_r  <= rd_data_s;
        end else if (last_beat_s) begin
            cfg_valid_r <= 1'b0;
        end else if (cfg_fire_s && (state_r == LOAD)) begin
            cfg_addr_r  <= rd_addr_s;
            cfg_data_r  <= rd_data_s;
        end
    end

    assign cfg_valid = cfg_valid_r;
    assign cfg_addr  = cfg_addr_r;
    assign cfg_data  = cfg_data_r;
    assign load_busy = load_busy_r;
    assign load_done = load_done_r;
    assign coef_ok   = coef_ok_r;
    assign host_err  = host_err_r;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with DWIDTH=8, AWIDTH=4, WINLEN=12.
module tb_fir_coef_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       host_we, host_err, load_start, load_busy, load_done, coef_ok;
    logic [3:0] host_addr, cfg_addr;
    logic [7:0] host_data, cfg_data, src_data, fir_din_data;
    logic       cfg_valid, cfg_busy, src_valid, src_busy, fir_din_valid, fir_din_busy;

    int total = 0;
    int bad   = 0;
    logic [11:0] beats[$];

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       fb;
        logic       loaded;
        logic       ev;
        logic       eb;
    } gate_vec_t;
    gate_vec_t gv[7];

    fir_coef_loader #(.DWIDTH(8), .AWIDTH(4), .WINLEN(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_we(host_we), .host_addr(host_addr), .host_data(host_data), .host_err(host_err),
        .load_start(load_start), .load_busy(load_busy), .load_done(load_done), .coef_ok(coef_ok),
        .cfg_valid(cfg_valid), .cfg_busy(cfg_busy), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .src_valid(src_valid), .src_busy(src_busy), .src_data(src_data),
        .fir_din_valid(fir_din_valid), .fir_din_busy(fir_din_busy), .fir_din_data(fir_din_data)
    );

    always #5 clk = ~clk;

    // Record every coefficient beat that will transfer on the coming edge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cfg_valid === 1'b1 && cfg_busy === 1'b0)
            beats.push_back({cfg_addr, cfg_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply_gate(input logic phase);
        for (int i = 0; i < 7; i++) begin
            if (gv[i].loaded == phase) begin
                src_valid = gv[i].sv; src_data = gv[i].sd; fir_din_busy = gv[i].fb;
                #1;
                chk($sformatf("gate_valid_%0d", i), fir_din_valid, gv[i].ev);
                chk($sformatf("gate_busy_%0d", i), src_busy, gv[i].eb);
                if (gv[i].ev) chk($sformatf("gate_data_%0d", i), fir_din_data, gv[i].sd);
            end
        end
        src_valid = 1'b0; fir_din_busy = 1'b0;
        #1;
    endtask

    task automatic write_bank();
        for (int i = 0; i < 12; i++) begin
            host_we = 1'b1; host_addr = 4'(i); host_data = 8'(i + 1);
            tick();
            chk("wr_no_err", host_err, 1'b0);
        end
        host_we = 1'b0;
    endtask

    // Full load from IDLE; optional stall at addr 5 and a rejected write during LOAD
    task automatic run_load(input int stall_n, input bit inject_we, input bit zero_bank, input bit exp_ok);
        int cyc;
        int holds;
        beats.delete();
        holds = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("first_valid", cfg_valid, 1'b1);
        chk("first_addr", cfg_addr, 4'd0);
        chk("first_data", cfg_data, zero_bank ? 8'd0 : 8'd1);
        chk("busy_on", load_busy, 1'b1);
        chk("coef_ok_during", coef_ok, exp_ok);
        chk("gate_shut", src_busy, 1'b1);
        cyc = 0;
        while (load_done !== 1'b1 && cyc < 60) begin
            if (cfg_valid && cfg_addr == 4'd5 && holds < stall_n) begin
                chk("stall_data", cfg_data, zero_bank ? 8'd0 : 8'd6);
                cfg_busy = 1'b1;
                holds++;
            end else begin
                cfg_busy = 1'b0;
            end
            if (inject_we && cyc == 3) chk("err_in_load", host_err, 1'b1);
            if (inject_we && cyc == 4) chk("err_pulse_end", host_err, 1'b0);
            host_we = (inject_we && cyc == 2);
            host_addr = 4'd3; host_data = 8'hAA;
            tick();
            cyc++;
        end
        host_we = 1'b0; cfg_busy = 1'b0;
        chk("done_seen", load_done, 1'b1);
        chk("done_latency", cyc, 12 + stall_n);
        chk("valid_off", cfg_valid, 1'b0);
        chk("busy_off", load_busy, 1'b0);
        chk("coef_ok_set", coef_ok, 1'b1);
        chk("beat_count", beats.size(), 12);
        for (int i = 0; i < 12 && i < beats.size(); i++)
            chk($sformatf("beat_%0d", i), beats[i], {4'(i), zero_bank ? 8'd0 : 8'(i + 1)});
        tick();
        chk("done_pulse_end", load_done, 1'b0);
    endtask

    initial begin
        int cyc;
        bit leak;
        gv[0] = '{1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        gv[1] = '{1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
        gv[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        gv[3] = '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0};
        gv[4] = '{1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b1};
        gv[5] = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0};
        gv[6] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; host_we = 1'b0; host_addr = 4'd0; host_data = 8'd0;
        load_start = 1'b0; cfg_busy = 1'b0; src_valid = 1'b0; src_data = 8'd0; fir_din_busy = 1'b0;
        tick(); tick();
        chk("rst_cfg_valid", cfg_valid, 1'b0);
        chk("rst_cfg_addr", cfg_addr, 4'd0);
        chk("rst_cfg_data", cfg_data, 8'd0);
        chk("rst_flags", {host_err, load_busy, load_done, coef_ok}, 4'b0000);
        rst_n = 1'b1;
        tick();

        write_bank();
        apply_gate(1'b0);
        run_load(0, 1'b0, 1'b0, 1'b0);
        apply_gate(1'b1);
        run_load(3, 1'b0, 1'b0, 1'b1);

        // Load request while a din beat is stalled: the load must wait for it
        src_valid = 1'b1; src_data = 8'h33; fir_din_busy = 1'b1; load_start = 1'b1;
        #1;
        chk("pend_offered", fir_din_valid, 1'b1);
        tick();
        load_start = 1'b0;
        chk("gate_no_cfg", cfg_valid, 1'b0);
        chk("gate_busy", load_busy, 1'b1);
        chk("gate_hold_valid", fir_din_valid, 1'b1);
        chk("gate_hold_data", fir_din_data, 8'h33);
        tick(); tick();
        chk("gate_still_no_cfg", cfg_valid, 1'b0);
        chk("gate_still_valid", fir_din_valid, 1'b1);
        fir_din_busy = 1'b0;
        #1;
        chk("gate_xfer_ready", src_busy, 1'b0);
        tick();
        src_data = 8'h44;
        chk("load_after_xfer", cfg_valid, 1'b1);
        chk("load_after_addr", cfg_addr, 4'd0);
        leak = 1'b0; cyc = 0;
        while (load_done !== 1'b1 && cyc < 40) begin
            if (src_busy !== 1'b1 || fir_din_valid !== 1'b0) leak = 1'b1;
            tick();
            cyc++;
        end
        chk("no_leak_during_load", leak, 1'b0);
        chk("gate_load_done", load_done, 1'b1);
        chk("gate_reopen_busy", src_busy, 1'b0);
        chk("gate_reopen_valid", fir_din_valid, 1'b1);
        src_valid = 1'b0;
        tick();

        run_load(0, 1'b1, 1'b0, 1'b1);
        host_we = 1'b1; host_addr = 4'd12; host_data = 8'hEE;
        tick();
        host_we = 1'b0;
        chk("err_oob", host_err, 1'b1);
        tick();
        chk("err_oob_end", host_err, 1'b0);
        run_load(0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset while beat 7 is offered
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        cyc = 0;
        while (!(cfg_valid === 1'b1 && cfg_addr == 4'd7) && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("reached_beat7", cfg_addr, 4'd7);
        src_valid = 1'b1; src_data = 8'h66; fir_din_busy = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", cfg_valid, 1'b0);
        chk("arst_coef_ok", coef_ok, 1'b0);
        chk("arst_load_busy", load_busy, 1'b0);
        chk("arst_src_busy", src_busy, 1'b1);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_blocked", fir_din_valid, 1'b0);
        run_load(0, 1'b0, 1'b1, 1'b0);
        chk("post_reload_pass", fir_din_valid, 1'b1);
        chk("post_reload_ready", src_busy, 1'b0);
        src_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
